// File: rtl/exp_datapath.sv
// exp_datapath: operand/term/accumulator datapath for the Maclaurin-series
// exponential unit. Evaluates e^x ~ sum_{k=0..NTERMS} x^k/k! in signed fixed
// point, one strobe per operation, driven by the exponential controller.
// Optional feature macro: EXP_DP_SAT_EN (saturating arithmetic + sticky ovf).
module exp_datapath #(
  parameter int W      = 16,
  parameter int FRAC   = 12,
  parameter int NTERMS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] xin,
  input  logic         ldX,
  input  logic         initT1,
  input  logic         initE1,
  input  logic         ldT,
  input  logic         ldE,
  input  logic         init0,
  input  logic         cntUp,
  input  logic         selXR,
  output logic         cnt8,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CW-1:0] CLAST = CW'(NTERMS - 1);
  localparam logic [W-1:0]  ONE   = W'(1 << FRAC);

  logic signed [W-1:0]     x_q, t_q, e_q;
  logic [CW-1:0]           cnt;
  logic [NTERMS-1:0][W-1:0] rom;
  logic signed [W-1:0]     mul_b, mul_res, add_res;
  logic signed [2*W-1:0]   prod, prod_sh;
  logic signed [W:0]       sum;

  // Reciprocal table 1/(k+1) in Q(FRAC), folded to constants at elaboration
  for (genvar k = 0; k < NTERMS; k++) begin : g_rom
    assign rom[k] = W'((1 << FRAC) / (k + 1));
  end

  // Multiplier: T times X or R, floor via arithmetic shift
  always_comb begin
    mul_b   = selXR ? x_q : $signed(rom[cnt]);
    prod    = t_q * mul_b;
    prod_sh = prod >>> FRAC;
    sum     = {e_q[W-1], e_q} + {t_q[W-1], t_q};
  end

`ifdef EXP_DP_SAT_EN
  localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]   SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   SMIN = {1'b1, {(W-1){1'b0}}};
  logic mul_ovf, add_ovf, ovf_q;

  // Clamp product and sum into W bits, flagging any clamp
  always_comb begin
    mul_ovf = (prod_sh > PMAX) || (prod_sh < PMIN);
    add_ovf = sum[W] != sum[W-1];
    mul_res = mul_ovf ? (prod_sh[2*W-1] ? SMIN : SMAX) : prod_sh[W-1:0];
    add_res = add_ovf ? (sum[W] ? SMIN : SMAX) : sum[W-1:0];
  end

  // Sticky overflow, cleared at the start of each evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= (initE1 ? 1'b0 : ovf_q)
                    | (ldT & ~initT1 & mul_ovf)
                    | (ldE & ~initE1 & add_ovf);
  end
  assign ovf = ovf_q;
`else
  // Wrap-around arithmetic: keep the low W bits
  always_comb begin
    mul_res = prod_sh[W-1:0];
    add_res = sum[W-1:0];
  end
  assign ovf = 1'b0;
`endif

  // Operand, term and accumulator registers; init strobes win over loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      t_q <= '0;
      e_q <= '0;
    end else begin
      if (ldX)         x_q <= xin;
      if (initT1)      t_q <= ONE;
      else if (ldT)    t_q <= mul_res;
      if (initE1)      e_q <= ONE;
      else if (ldE)    e_q <= add_res;
    end
  end

  // Term counter, wraps after the last term
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (init0)    cnt <= '0;
    else if (cntUp)    cnt <= (cnt == CLAST) ? '0 : cnt + 1'b1;
  end

  assign cnt8   = (cnt == CLAST);
  assign result = e_q;

endmodule
